// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses to a word-wide data memory.
// Sub-word stores are read-modify-write; sub-word loads are lane-extracted and extended.
module load_store_unit #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned AWIDTH = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_misaligned,
    output logic              mem_en,
    output logic              mem_wen,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_lane;
    logic [15:0] r_wdata;

    logic            w_misaligned;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load;
    logic [XLEN-1:0] w_merged;
    logic            w_unused_addr;

    // Address bits above the memory range are deliberately dropped.
    assign w_unused_addr = ^req_addr[XLEN-1:AWIDTH];

    assign w_misaligned = (req_size == 2'b11)
                       || (req_size == SZ_HALF && req_addr[0])
                       || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);

    assign w_byte = mem_rdata[{r_lane, 3'b000} +: 8];
    assign w_half = mem_rdata[{r_lane[1], 4'b0000} +: 16];

    // Load lane extraction and extension; word loads ignore r_unsigned.
    always_comb begin
        w_load = mem_rdata;
        case (r_size)
            SZ_BYTE: w_load = {{(XLEN-8){~r_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: w_load = {{(XLEN-16){~r_unsigned & w_half[15]}}, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    // Store merge: overwrite the target lane(s) of the fetched word.
    always_comb begin
        w_merged = mem_rdata;
        if (r_size == SZ_BYTE)
            w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        else
            w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_write        <= 1'b0;
            r_size         <= 2'b00;
            r_unsigned     <= 1'b0;
            r_lane         <= 2'b00;
            r_wdata        <= 16'h0;
            req_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_misaligned <= 1'b0;
            mem_en         <= 1'b0;
            mem_wen        <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
        end else begin
            rsp_valid      <= 1'b0;
            rsp_misaligned <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_write    <= req_write;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_lane     <= req_addr[1:0];
                        r_wdata    <= req_wdata[15:0];
                        mem_addr   <= {req_addr[AWIDTH-1:2], 2'b00};
                        req_ready  <= 1'b0;
                        rsp_rdata  <= '0;
                        if (w_misaligned) begin
                            rsp_valid      <= 1'b1;
                            rsp_misaligned <= 1'b1;
                            r_state        <= RESP;
                        end else if (req_write && req_size == SZ_WORD) begin
                            mem_en    <= 1'b1;
                            mem_wen   <= 1'b1;
                            mem_wdata <= req_wdata;
                            r_state   <= WR;
                        end else begin
                            mem_en  <= 1'b1;
                            r_state <= RD;
                        end
                    end
                end
                RD: begin
                    mem_en  <= 1'b0;
                    r_state <= CAP;
                end
                CAP: begin
                    if (!r_write) begin
                        rsp_rdata <= w_load;
                        rsp_valid <= 1'b1;
                        r_state   <= RESP;
                    end else begin
                        mem_en    <= 1'b1;
                        mem_wen   <= 1'b1;
                        mem_wdata <= w_merged;
                        r_state   <= WR;
                    end
                end
                WR: begin
                    mem_en    <= 1'b0;
                    mem_wen   <= 1'b0;
                    mem_wdata <= '0;
                    rsp_valid <= 1'b1;
                    r_state   <= RESP;
                end
                RESP: begin
                    rsp_rdata <= '0;
                    req_ready <= 1'b1;
                    r_state   <= IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    mem_en    <= 1'b0;
                    mem_wen   <= 1'b0;
                    mem_wdata <= '0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a one-cycle-latency word memory model.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misaligned;
    logic        mem_en;
    logic        mem_wen;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    load_store_unit #(.XLEN(32), .AWIDTH(10)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_misaligned(rsp_misaligned), .mem_en(mem_en), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    logic [31:0] mem [256];
    int          en_cnt = 0;
    int          wr_cnt = 0;
    int          acc_cnt = 0;
    logic [9:0]  last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    // Memory model plus activity counters.
    always @(posedge clock) begin
        if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
        if (mem_en) begin
            en_cnt <= en_cnt + 1;
            if (mem_wen) begin
                mem[mem_addr[9:2]] <= mem_wdata;
                wr_cnt       <= wr_cnt + 1;
                last_wr_addr <= mem_addr;
                last_wr_data <= mem_wdata;
            end else begin
                mem_rdata <= mem[mem_addr[9:2]];
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    logic [31:0] r_data;
    logic        r_mis;
    int          r_lat, r_wr_at, r_n_en, r_n_wr;

    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d);
        int en0, wr0;
        en0 = en_cnt; wr0 = wr_cnt;
        r_data = '0; r_mis = 1'b0; r_lat = 0; r_wr_at = 0;
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (mem_wen && r_wr_at == 0) r_wr_at = k;
            if (rsp_valid) begin
                r_lat = k; r_data = rsp_rdata; r_mis = rsp_misaligned;
                break;
            end
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
        r_n_en = en_cnt - en0;
        r_n_wr = wr_cnt - wr0;
    endtask

    logic [31:0] h_addr [3] = '{32'h023, 32'h020, 32'h020};
    logic [1:0]  h_size [3] = '{2'b00, 2'b01, 2'b10};
    logic        h_uns  [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] h_exp  [3] = '{32'hFFFFFF80, 32'h00007F01, 32'h80FF7F01};

    initial begin
        logic [31:0] got_q [$];
        int idx, a0, acc0, wr_before;

        #12;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;

        do_req(1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF);
        check("sw_lat", 32'(r_lat), 32'd2);
        check("sw_wr_at", 32'(r_wr_at), 32'd1);
        check("sw_nwr", 32'(r_n_wr), 32'd1);
        check("sw_addr", 32'(last_wr_addr), 32'h010);
        check("sw_data", last_wr_data, 32'hDEADBEEF);
        check("sw_rdata", r_data, 32'h0);

        do_req(1'b0, 2'b10, 1'b0, 32'h010, 32'h0);
        check("lw_lat", 32'(r_lat), 32'd3);
        check("lw_data", r_data, 32'hDEADBEEF);
        check("lw_nen", 32'(r_n_en), 32'd1);
        check("lw_nwr", 32'(r_n_wr), 32'd0);

        do_req(1'b1, 2'b10, 1'b0, 32'h020, 32'h80FF7F01);
        do_req(1'b0, 2'b00, 1'b0, 32'h023, 32'h0);
        check("lb", r_data, 32'hFFFFFF80);
        do_req(1'b0, 2'b00, 1'b1, 32'h023, 32'h0);
        check("lbu", r_data, 32'h00000080);
        do_req(1'b0, 2'b01, 1'b0, 32'h022, 32'h0);
        check("lh", r_data, 32'hFFFF80FF);
        do_req(1'b0, 2'b01, 1'b1, 32'h020, 32'h0);
        check("lhu", r_data, 32'h00007F01);
        check("lhu_lat", 32'(r_lat), 32'd3);

        do_req(1'b1, 2'b10, 1'b0, 32'h030, 32'h11223344);
        do_req(1'b1, 2'b00, 1'b0, 32'h031, 32'h123456AA);
        check("sb_wr_at", 32'(r_wr_at), 32'd3);
        check("sb_lat", 32'(r_lat), 32'd4);
        check("sb_nwr", 32'(r_n_wr), 32'd1);
        check("sb_nen", 32'(r_n_en), 32'd2);
        check("sb_word", last_wr_data, 32'h1122AA44);
        do_req(1'b1, 2'b01, 1'b0, 32'h032, 32'hFFFFBEEF);
        check("sh_word", last_wr_data, 32'hBEEFAA44);
        check("sh_mem", mem[12], 32'hBEEFAA44);

        do_req(1'b0, 2'b10, 1'b0, 32'h005, 32'h0);
        check("mis_lw_lat", 32'(r_lat), 32'd1);
        check("mis_lw_flag", 32'(r_mis), 32'd1);
        check("mis_lw_nen", 32'(r_n_en), 32'd0);
        do_req(1'b1, 2'b01, 1'b0, 32'h007, 32'h12345678);
        check("mis_sh_lat", 32'(r_lat), 32'd1);
        check("mis_sh_flag", 32'(r_mis), 32'd1);
        check("mis_sh_nen", 32'(r_n_en), 32'd0);
        do_req(1'b0, 2'b11, 1'b0, 32'h000, 32'h0);
        check("mis_sz3_lat", 32'(r_lat), 32'd1);
        check("mis_sz3_flag", 32'(r_mis), 32'd1);
        check("mis_sz3_rdata", r_data, 32'h0);
        check("mis_sz3_nen", 32'(r_n_en), 32'd0);
        check("mem_0x30_kept", mem[12], 32'hBEEFAA44);

        // Three loads with req_valid held high throughout.
        idx = 0; acc0 = acc_cnt;
        req_write = 1'b0; req_size = h_size[0]; req_unsigned = h_uns[0]; req_addr = h_addr[0];
        req_valid = 1'b1;
        for (int c = 0; c < 60 && got_q.size() < 3; c++) begin
            a0 = acc_cnt;
            @(posedge clock); #1;
            if (rsp_valid) got_q.push_back(rsp_rdata);
            if (acc_cnt != a0) begin
                idx++;
                if (idx < 3) begin
                    req_size = h_size[idx]; req_unsigned = h_uns[idx]; req_addr = h_addr[idx];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("held_accepts", 32'(acc_cnt - acc0), 32'd3);
        check("held_rsps", 32'(got_q.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("held_rsp%0d", i), (i < got_q.size()) ? got_q[i] : 32'hXXXXXXXX, h_exp[i]);

        // Reset during CAP of a byte store.
        do_req(1'b1, 2'b10, 1'b0, 32'h040, 32'h55667788);
        wr_before = wr_cnt;
        req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h041; req_wdata = 32'h000000AA; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check("arst_ready", 32'(req_ready), 32'd1);
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_mem_en", 32'(mem_en), 32'd0);
        check("arst_mem_wen", 32'(mem_wen), 32'd0);
        check("arst_mem_addr", 32'(mem_addr), 32'h0);
        check("arst_mem_wdata", mem_wdata, 32'h0);
        check("arst_rdata", rsp_rdata, 32'h0);
        repeat (3) @(posedge clock);
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;
        check("arst_no_write", 32'(wr_cnt - wr_before), 32'd0);
        check("arst_mem_kept", mem[16], 32'h55667788);
        do_req(1'b0, 2'b10, 1'b0, 32'h040, 32'h0);
        check("post_rst_lat", 32'(r_lat), 32'd3);
        check("post_rst_data", r_data, 32'h55667788);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the core's data-memory port and the word-wide `rwmemory` data memory. It accepts one byte, halfword or word access at a time over a valid/ready handshake. Sub-word stores are done as a read-modify-write of the containing word, and sub-word loads are lane-extracted and sign- or zero-extended. Misaligned requests are rejected without touching memory.

## Interface
- `XLEN`, 32, data/address width
- `AWIDTH`, 10, memory byte-address width passed to `rwmemory`

- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit idle, request accepted when both high
- `req_write`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `req_unsigned`  in  1  loads only: zero-extend instead of sign-extend
- `req_addr`  in  XLEN  byte address
- `req_wdata`  in  XLEN  store data, right-justified
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_rdata`  out  XLEN  load result (0 for stores/faults)
- `rsp_misaligned`  out  1  qualifies `rsp_valid`: access rejected
- `mem_en`  out  1  memory enable
- `mem_wen`  out  1  memory write enable
- `mem_addr`  out  AWIDTH  word-aligned byte address, bits [1:0] = 00
- `mem_wdata`  out  XLEN  full word to write
- `mem_rdata`  in  XLEN  memory read data, valid the cycle after a read

## Operation
- Byte lanes are little-endian: byte k occupies bits [8k+7:8k]; halfword at `addr[1]` occupies bits [16h+15:16h].
- On acceptance, latch `req_*` and set `mem_addr = {req_addr[AWIDTH-1:2],2'b00}`. Upper address bits are ignored.
- Misaligned cases:
  - half with `addr[0]`=1
  - word with `addr[1:0]`≠0
  - size 11 (any address)
- FSM states: IDLE, RD, CAP, WR, RESP.
- IDLE: `req_ready`=1. On accept:
  - misaligned → RESP
  - word store → WR
  - everything else → RD
- RD: `mem_en`=1, `mem_wen`=0 → CAP.
- CAP: sample `mem_rdata`.
  - Load: extract lane, extend per `req_unsigned` (word ignores it), register into `rsp_rdata` → RESP.
  - Store: replace target lane(s) with low bits of `req_wdata`, keep other bytes, register merged word → WR.
- WR: `mem_en`=1, `mem_wen`=1, `mem_wdata` = merged word (or `req_wdata` for word store) → RESP.
- RESP: `rsp_valid`=1 for exactly one cycle, `rsp_misaligned` per the latched check → IDLE. There is no response backpressure.
- `mem_en`/`mem_wen` are 0 in IDLE, CAP and RESP. `mem_wdata` is 0 outside WR.

## Timing
- Request accepted at edge T (IDLE, `req_valid`=1).
- Responses (`rsp_valid` high during cycle):
  - misaligned: T+1
  - word store: T+2
  - load: T+3
  - sub-word store: T+4
- Exactly one memory write per store. No memory access for a misaligned request.
- `req_ready` is low from T+1 until the cycle after RESP. The earliest back-to-back acceptance is the edge ending RESP+1 (IDLE). Requests presented while not ready are ignored and must be held by the core.
- All outputs are registered from state and latches. There is no combinational path from `req_*` to `mem_*`.
- Reset (async, `reset`=0) values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_misaligned`=0, `rsp_rdata`=0, `mem_en`=0, `mem_wen`=0, `mem_addr`=0, `mem_wdata`=0.
- Reset mid-operation aborts immediately. A write in WR is lost if reset falls before its clock edge, and no response is produced.
- Read data is not forwarded from a preceding write; memory ordering is guaranteed by the single-outstanding protocol.

## Test plan
- Word store 0xDEADBEEF to 0x010, then word load 0x010 → one WR with `mem_addr`=0x010; `rsp_rdata`=0xDEADBEEF at T+3; store `rsp_valid` at T+2.
- Memory word 0x80FF7F01 at 0x020: LB at 0x023 → 0xFFFFFF80; LBU at 0x023 → 0x00000080; LH at 0x022 → 0xFFFF80FF; LHU at 0x020 → 0x00007F01.
- Memory word 0x11223344 at 0x030: SB 0xAA to 0x031 → written word 0x1122AA44 at T+3, response T+4; then SH 0xBEEF to 0x032 → 0xBEEFAA44.
- LW at 0x005, SH at 0x007, and size 11 at 0x000 → each gives `rsp_valid` at T+1 with `rsp_misaligned`=1, `rsp_rdata`=0, and `mem_en` never asserted.
- `req_valid` held high continuously with three loads → each accepted only in IDLE; no request is dropped or duplicated; responses stay in order.
- Assert `reset`=0 during CAP of an SB → all outputs immediately at reset values, the memory word is unchanged, and the first request after release completes normally.
